iob_2p_mem_tiled: RTL and testbench
===================================

IOB_2P_MEM_TILED -- requirements
Module: iob_2p_mem_tiled

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits.
REQ-002 Parameter N_WORDS, default 8000: total addressable words.
REQ-003 Parameter TILE_ADDR_W, default 13: address width of one tile; tile depth 2^TILE_ADDR_W words.
REQ-004 Parameter USE_RAM, default 0: 0 = output follows the address every cycle; 1 = output register gated by r_en.
REQ-005 Derived ADDR_W = $clog2(N_WORDS*DATA_W/8), which is 14 at defaults.
REQ-006 Derived N_TILES = ceil(N_WORDS / 2^TILE_ADDR_W), which is 1 at defaults.
REQ-007 clk, input, 1: single clock; all logic is on its rising edge.
REQ-008 rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 w_en, input, 1: write enable.
REQ-010 r_en, input, 1: read enable.
REQ-011 data_in, input, DATA_W: write data.
REQ-012 addr, input, ADDR_W: word address, shared by read and write.
REQ-013 data_out, output, DATA_W: read data.

Function
REQ-014 Storage SHALL be N_TILES independent tiles, each 2^TILE_ADDR_W x DATA_W.
REQ-015 Tile select SHALL be addr[ADDR_W-1:TILE_ADDR_W], zero-width when ADDR_W <= TILE_ADDR_W. The in-tile offset SHALL be addr[TILE_ADDR_W-1:0].
REQ-016 With w_en=1 at a rising edge and addr < N_WORDS, data_in SHALL be stored at addr in the selected tile only. No other word SHALL change.
REQ-017 Writes with addr >= N_WORDS SHALL be ignored.
REQ-018 Read latency SHALL be one cycle: data_out after edge k reflects the word at the addr sampled at edge k.
REQ-019 The tile select SHALL be registered with the read, so the output mux uses the tile index from the same edge.
REQ-020 USE_RAM=0: the read SHALL occur on every edge regardless of r_en.
REQ-021 USE_RAM=1: data_out SHALL update only on edges where r_en=1, and SHALL hold its previous value otherwise.
REQ-022 A read of addr >= N_WORDS SHALL return 0.
REQ-023 Simultaneous read and write to the same address SHALL return the old (pre-write) data, i.e. read-before-write. The new data SHALL be visible from the next read.
REQ-024 Back-to-back accesses to different tiles SHALL incur no stall or bubble.
REQ-025 Tile storage contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-026 While rst_n=0, data_out and the registered tile select SHALL be 0, asynchronously.
REQ-027 Writes SHALL be suppressed while rst_n=0.
REQ-028 Operation SHALL resume at the first rising edge after rst_n deasserts.
REQ-029 Reset asserted mid-operation SHALL clear only data_out and pipeline registers. Stored words SHALL be retained.

Verification
REQ-030 Write sweep: w_en=1, addr 0..15, data_in = addr+32; then w_en=0, r_en=1, read addr 0..15 -> data_out = addr+32 one cycle after each address.
REQ-031 USE_RAM=1, after reset and the write sweep, r_en=0, read sweep 0..15 -> data_out stays 0 throughout. Then r_en=1 -> data_out = addr+32.
REQ-032 USE_RAM=0, r_en=0 read sweep after the write sweep -> data_out = addr+32 with one-cycle latency.
REQ-033 Tile boundary, TILE_ADDR_W=4, N_WORDS=40: write addr 15=0xAAAA, 16=0x5555, 39=0x1234 -> reads return the same values.
REQ-034 Tile boundary, same configuration: read addr 40 -> 0.
REQ-035 Same-cycle write 0x0BEE and read at addr 5 holding 0x0025 -> data_out 0x0025, then 0x0BEE on the next read.
REQ-036 Assert rst_n=0 mid-read -> data_out 0 immediately. After release, reading addr 3 -> the previously written value 35.

Source files
------------

// File: rtl/iob_2p_mem_tiled.sv
// Tiled single-port-address RAM: N_TILES independent tiles, one-cycle registered read,
// read-before-write on a shared address, out-of-range reads return 0.
module iob_2p_mem_tiled #(
  parameter  int DATA_W      = 16,
  parameter  int N_WORDS     = 8000,
  parameter  int TILE_ADDR_W = 13,
  parameter  int USE_RAM     = 0,
  localparam int ADDR_W      = $clog2(N_WORDS * DATA_W / 8),
  localparam int N_TILES     = (N_WORDS + 2**TILE_ADDR_W - 1) / 2**TILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out
);
  // Widen the address so the tile select is at least one bit (stuck at 0 when
  // the whole address space fits in a single tile).
  localparam int EXT_W = (ADDR_W > TILE_ADDR_W) ? ADDR_W : TILE_ADDR_W + 1;
  localparam int SEL_W = EXT_W - TILE_ADDR_W;
  localparam int DEPTH = 2**TILE_ADDR_W;

  logic [EXT_W-1:0]               w_addr;
  logic [TILE_ADDR_W-1:0]         w_off;
  logic [SEL_W-1:0]               w_sel;
  logic                           w_in_rng;
  logic                           w_rd;
  logic [N_TILES-1:0][DATA_W-1:0] w_q;
  logic [DATA_W-1:0]              w_mux;
  logic [SEL_W-1:0]               r_sel;
  logic                           r_oor;

  assign w_addr   = EXT_W'(addr);
  assign w_off    = w_addr[TILE_ADDR_W-1:0];
  assign w_sel    = w_addr[EXT_W-1:TILE_ADDR_W];
  assign w_in_rng = {1'b0, addr} < (ADDR_W+1)'(N_WORDS);
  assign w_rd     = (USE_RAM == 0) || r_en;

  // Tile select and range flag travel with the read so the output mux is aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
      r_oor <= 1'b0;
    end else if (w_rd) begin
      r_sel <= w_sel;
      r_oor <= !w_in_rng;
    end
  end

  for (genvar t = 0; t < N_TILES; t++) begin : g_tile
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    logic              w_we;

    assign w_we = w_en && w_in_rng && (w_sel == SEL_W'(t));

    // Storage is never cleared; the reset edge only blocks writes while low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n && w_we) mem[w_off] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_q <= '0;
      else if (w_rd) r_q <= mem[w_off];
    end

    assign w_q[t] = r_q;
  end

  always_comb begin
    w_mux = '0;
    for (int t = 0; t < N_TILES; t++)
      if (r_sel == SEL_W'(t)) w_mux = w_q[t];
  end

  assign data_out = r_oor ? '0 : w_mux;
endmodule

// File: tb/tb_iob_2p_mem_tiled.sv
// Drives three configurations from shared stimulus and checks them against a
// word-addressed associative-array model of the memory.
module tb_iob_2p_mem_tiled;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_en, r_en;
  logic [15:0]       data_in;
  logic [13:0]       addr;
  logic [2:0][15:0]  dout;

  int n_chk  = 0;
  int n_pass = 0;

  localparam int NW   [3] = '{8000, 8000, 40};
  localparam int UR   [3] = '{0, 1, 0};
  localparam int AMSK [3] = '{16383, 16383, 127};

  logic [15:0] mdl [int];
  logic [15:0] exp_v [3];
  bit          exp_k [3];

  always #5 clk = ~clk;

  iob_2p_mem_tiled #(.USE_RAM(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .addr(addr), .data_out(dout[0]));
  iob_2p_mem_tiled #(.USE_RAM(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .addr(addr), .data_out(dout[1]));
  iob_2p_mem_tiled #(.N_WORDS(40), .TILE_ADDR_W(4), .USE_RAM(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .addr(addr[6:0]), .data_out(dout[2]));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++)
      if (exp_k[d]) chk($sformatf("%s_d%0d", tag, d), dout[d], exp_v[d]);
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then compare.
  task automatic cyc(input string tag);
    int a;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      a = int'(addr) & AMSK[d];
      if (!rst_n) begin
        exp_v[d] = '0; exp_k[d] = 1'b1;
      end else if (UR[d] == 0 || r_en) begin
        if (a >= NW[d])                   begin exp_v[d] = '0;               exp_k[d] = 1'b1; end
        else if (mdl.exists(d*65536 + a)) begin exp_v[d] = mdl[d*65536 + a]; exp_k[d] = 1'b1; end
        else                                exp_k[d] = 1'b0;
      end
    end
    for (int d = 0; d < 3; d++) begin
      a = int'(addr) & AMSK[d];
      if (rst_n && w_en && a < NW[d]) mdl[d*65536 + a] = data_in;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0; addr = '0;
    for (int d = 0; d < 3; d++) begin exp_v[d] = '0; exp_k[d] = 1'b1; end
    #1 rst_n = 1'b0;
    #2 check_all("reset");
    w_en = 1'b1; addr = 14'd3; data_in = 16'hDEAD;
    cyc("rst_hold");
    cyc("rst_hold");
    rst_n = 1'b1; w_en = 1'b0;

    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; addr = 14'(i); data_in = 16'(i + 32);
      cyc("wsweep");
    end
    w_en = 1'b0; r_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 14'(i);
      cyc("rsweep_ren0");
    end
    r_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr = 14'(i);
      cyc("rsweep_ren1");
      chk("sweep_abs", dout[0], 16'(i + 32));
    end

    w_en = 1'b1;
    addr = 14'd15; data_in = 16'hAAAA; cyc("tile_wr");
    addr = 14'd16; data_in = 16'h5555; cyc("tile_wr");
    addr = 14'd39; data_in = 16'h1234; cyc("tile_wr");
    w_en = 1'b0;
    addr = 14'd15; cyc("tile_rd"); chk("tile15", dout[2], 16'hAAAA);
    addr = 14'd16; cyc("tile_rd"); chk("tile16", dout[2], 16'h5555);
    addr = 14'd39; cyc("tile_rd"); chk("tile39", dout[2], 16'h1234);
    addr = 14'd40; cyc("tile_rd"); chk("tile40_oor", dout[2], 16'h0000);
    addr = 14'd8000; cyc("oor_top");

    w_en = 1'b1; addr = 14'd5; data_in = 16'h0BEE;
    cyc("rbw"); chk("rbw_old", dout[0], 16'h0025);
    w_en = 1'b0;
    cyc("rbw"); chk("rbw_new", dout[0], 16'h0BEE);

    addr = 14'd7; cyc("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin exp_v[d] = '0; exp_k[d] = 1'b1; end
    check_all("async_rst");
    w_en = 1'b1; addr = 14'd3; data_in = 16'hFFFF;
    cyc("rst_wr_blocked");
    rst_n = 1'b1; w_en = 1'b0; r_en = 1'b1;
    cyc("post_rst"); chk("rst_keep", dout[0], 16'd35);

    for (int n = 0; n < 400; n++) begin
      w_en    = 1'($urandom_range(0, 1));
      r_en    = 1'($urandom_range(0, 1));
      data_in = 16'($urandom);
      addr    = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(7990, 8200))
                                            : 14'($urandom_range(0, 63));
      cyc("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
